// File: rtl/sar_adc_ctrl_pkg.sv
// Shared definitions for the crossbar column readout and the DAC sequencer.
// Holds the conversion FSM state encodings, the default widths, and a sizing helper.
// No ports; import with "import sar_adc_ctrl_pkg::*;".
package sar_adc_ctrl_pkg;

  // The DAC sequencer decodes these same values, so keep them fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_CONV   = 2'd2,
    ST_DONE   = 2'd3
  } adc_state_t;

  localparam int DEF_N_BITS        = 8;
  localparam int DEF_N_CH          = 4;
  localparam int DEF_SAMPLE_CYCLES = 2;
  localparam int DEF_SETTLE_CYCLES = 2;

  // Width of a down-counter that can be loaded with the larger of two cycle counts.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/adc_settle_timer.sv
// Loadable down-counter that times the track/hold and per-bit settle windows.
// Latency: done is high in the last cycle of a window of load_val cycles, starting in the cycle after load.
// Backpressure: none; a load restarts the count.
// Ports: clk, rst (sync, active-high), load/load_val (start a window), done (last cycle of window).
module adc_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // cnt counts the cycles left in the window, including the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR readout of one crossbar column per start: track/hold, then an N_BITS binary search using the reference DAC.
// Latency: valid_o is high in the cycle after edge E+SAMPLE_CYCLES+N_BITS*SETTLE_CYCLES, where E is the accepting edge.
// Backpressure: none; start_i is accepted only in IDLE/DONE, and a start seen while busy is dropped.
// Ports: wb_clk_i/wb_rst_i (sync, active-high); start_i/ch_i request; cmp_i comparator;
//        mux_sel_o/sample_o/trial_o analog controls; busy_o; valid_o/data_o/ch_o result (all registered).
module sar_adc_ctrl
  import sar_adc_ctrl_pkg::*;
#(
  parameter int N_BITS        = DEF_N_BITS,
  parameter int N_CH          = DEF_N_CH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
`ifdef USE_POWER_PINS
  inout  wire                      vccd1,
  inout  wire                      vssd1,
`endif
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start_i,
  input  logic [$clog2(N_CH)-1:0]  ch_i,
  input  logic                     cmp_i,
  output logic [$clog2(N_CH)-1:0]  mux_sel_o,
  output logic                     sample_o,
  output logic [N_BITS-1:0]        trial_o,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [N_BITS-1:0]        data_o,
  output logic [$clog2(N_CH)-1:0]  ch_o
);

  localparam int CW = $clog2(N_CH);
  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int TW = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);

  localparam logic [N_BITS-1:0] ONE      = N_BITS'(1);
  localparam logic [BW-1:0]     TOP_BIT  = BW'(N_BITS - 1);
  localparam logic [TW-1:0]     SMP_LOAD = TW'(SAMPLE_CYCLES);
  localparam logic [TW-1:0]     STL_LOAD = TW'(SETTLE_CYCLES);
  localparam logic [CW:0]       N_CH_W   = (CW+1)'(N_CH);

  adc_state_t          state, state_nxt;
  logic [N_BITS-1:0]   result, res_nxt;
  logic [BW-1:0]       bit_idx, idx_nxt;
  logic [CW-1:0]       mux_nxt, cho_nxt, ch_wrap;
  logic [CW:0]         ch_ext;
  logic [N_BITS-1:0]   trial_nxt, data_nxt;
  logic                sample_nxt, busy_nxt, valid_nxt;
  logic                tmr_load, tmr_done;
  logic [TW-1:0]       tmr_val;

  adc_settle_timer #(.W(TW)) u_timer (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // ch_i is clog2(N_CH) bits wide, so it is always below 2*N_CH.
  // A single conditional subtract is therefore the full modulo.
  always_comb begin
    ch_ext = {1'b0, ch_i};
    if (ch_ext >= N_CH_W) begin
      ch_ext = ch_ext - N_CH_W;
    end
    ch_wrap = ch_ext[CW-1:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      result    <= '0;
      bit_idx   <= '0;
      mux_sel_o <= '0;
      sample_o  <= 1'b0;
      trial_o   <= '0;
      busy_o    <= 1'b0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      ch_o      <= '0;
    end else begin
      state     <= state_nxt;
      result    <= res_nxt;
      bit_idx   <= idx_nxt;
      mux_sel_o <= mux_nxt;
      sample_o  <= sample_nxt;
      trial_o   <= trial_nxt;
      busy_o    <= busy_nxt;
      valid_o   <= valid_nxt;
      data_o    <= data_nxt;
      ch_o      <= cho_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    res_nxt    = result;
    idx_nxt    = bit_idx;
    mux_nxt    = mux_sel_o;
    sample_nxt = 1'b0;
    trial_nxt  = '0;
    busy_nxt   = 1'b0;
    valid_nxt  = 1'b0;
    data_nxt   = data_o;
    cho_nxt    = ch_o;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a start directly, giving back-to-back conversions with no idle cycle.
        if (start_i) begin
          state_nxt  = ST_SAMPLE;
          mux_nxt    = ch_wrap;
          sample_nxt = 1'b1;
          busy_nxt   = 1'b1;
          res_nxt    = '0;
          idx_nxt    = TOP_BIT;
          tmr_load   = 1'b1;
          tmr_val    = SMP_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_SAMPLE: begin
        busy_nxt = 1'b1;
        if (tmr_done) begin
          state_nxt = ST_CONV;
          trial_nxt = ONE << (N_BITS - 1);
          tmr_load  = 1'b1;
          tmr_val   = STL_LOAD;
        end else begin
          sample_nxt = 1'b1;
        end
      end

      ST_CONV: begin
        busy_nxt  = 1'b1;
        trial_nxt = trial_o;
        // cmp_i is read only on the last settle cycle of each bit.
        // Any value it carries during other cycles cannot reach state.
        if (tmr_done) begin
          res_nxt[bit_idx] = cmp_i;
          if (bit_idx == '0) begin
            state_nxt = ST_DONE;
            busy_nxt  = 1'b0;
            trial_nxt = '0;
            valid_nxt = 1'b1;
            data_nxt  = res_nxt;
            cho_nxt   = mux_sel_o;
          end else begin
            idx_nxt   = bit_idx - BW'(1);
            trial_nxt = res_nxt | (ONE << idx_nxt);
            tmr_load  = 1'b1;
            tmr_val   = STL_LOAD;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
